stopwatch_ctrl: RTL and testbench

Run-control sequencer for the stopwatch datapath. It holds a BCD MM:SS time count and advances it once per second while running. It services start/stop, clear, manual-adjust and (optionally) lap inputs. It drives the four digit values plus per-digit blank flags consumed by the seven-segment multiplexer.

---
 rtl/stopwatch_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/adjust sequencer for a BCD MM:SS stopwatch with adjust-mode blink.
// Optional lap freeze of the displayed digits is compiled in when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl #(
    parameter int DIV = 100000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_inc,
    input  logic       btn_lap,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_1,
    output logic [3:0] min_0,
    output logic [3:0] sec_1,
    output logic [3:0] sec_0,
    output logic       running,
    output logic [3:0] blank,
    output logic       tick
);

    localparam int PW = $clog2(DIV);
    localparam int BW = ($clog2(DIV / 2) > 0) ? $clog2(DIV / 2) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(DIV / 2 - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, ADJ} state_t;

    typedef struct packed {
        logic [3:0] m1;
        logic [3:0] m0;
        logic [3:0] s1;
        logic [3:0] s0;
    } bcd_t;

    // Advance a tens/ones BCD pair by one, wrapping 59 -> 00.
    function automatic logic [7:0] pair_inc(input logic [3:0] tens, input logic [3:0] ones);
        if (ones != 4'd9)
            pair_inc = {tens, ones + 4'd1};
        else if (tens != 4'd5)
            pair_inc = {tens + 4'd1, 4'd0};
        else
            pair_inc = 8'h00;
    endfunction

    state_t          state_q, state_d;
    bcd_t            cnt_q, cnt_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic            phase_q, phase_d;
    logic            tick_d;
    logic [3:0]      blank_d;
    logic            wrap;
    logic            sec_carry;
    logic            clear_hit;
    logic            inc_hit;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d   = state_q;
        cnt_d     = cnt_q;
        tick_d    = 1'b0;
        clear_hit = 1'b0;
        inc_hit   = 1'b0;
        wrap      = (state_q == RUN) && (presc_q == PRESC_MAX);
        sec_carry = (cnt_q.s1 == 4'd5) && (cnt_q.s0 == 4'd9);

        case (state_q)
            IDLE: begin
                if (btn_clear)      clear_hit = 1'b1;
                else if (btn_start) state_d = RUN;
                else if (adj)       state_d = ADJ;
            end
            RUN: begin
                // Clear is ignored while running except on the prescaler wrap edge, where it beats the increment.
                if (wrap && btn_clear) begin
                    clear_hit = 1'b1;
                end else begin
                    if (wrap) begin
                        tick_d = 1'b1;
                        {cnt_d.s1, cnt_d.s0} = pair_inc(cnt_q.s1, cnt_q.s0);
                        if (sec_carry)
                            {cnt_d.m1, cnt_d.m0} = pair_inc(cnt_q.m1, cnt_q.m0);
                    end
                    if (btn_start) state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (btn_clear) begin
                    clear_hit = 1'b1;
                    state_d   = IDLE;
                end else if (btn_start) begin
                    state_d = RUN;
                end else if (adj) begin
                    state_d = ADJ;
                end
            end
            ADJ: begin
                if (btn_clear) begin
                    clear_hit = 1'b1;
                end else if (!adj) begin
                    state_d = (cnt_q == '0) ? IDLE : PAUSE;
                end else if (btn_inc) begin
                    inc_hit = 1'b1;
                    if (sel) {cnt_d.s1, cnt_d.s0} = pair_inc(cnt_q.s1, cnt_q.s0);
                    else     {cnt_d.m1, cnt_d.m0} = pair_inc(cnt_q.m1, cnt_q.m0);
                end
            end
            default: state_d = IDLE;
        endcase

        if (clear_hit) cnt_d = '0;

        // Entering RUN leaves the prescaler at 0, so the first increment lands a full second later.
        presc_d = '0;
        if (state_q == RUN && state_d == RUN)
            presc_d = wrap ? '0 : presc_q + PW'(1);

        bcnt_d  = '0;
        phase_d = 1'b0;
        if (state_d == ADJ && state_q == ADJ && !inc_hit) begin
            if (bcnt_q == BLINK_MAX) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d  = bcnt_q + BW'(1);
                phase_d = phase_q;
            end
        end

        blank_d = 4'b0000;
        if (state_d == ADJ && phase_d)
            blank_d = sel ? 4'b0011 : 4'b1100;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            presc_q <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            running <= 1'b0;
            blank   <= 4'b0000;
            tick    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            running <= (state_d == RUN);
            blank   <= blank_d;
            tick    <= tick_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic frozen_q, frozen_d;
    logic enter_adj;
    bcd_t disp_q;

    always_comb begin
        frozen_d  = frozen_q;
        enter_adj = (state_d == ADJ) && (state_q != ADJ);
        if (clear_hit || enter_adj)
            frozen_d = 1'b0;
        else if (btn_lap && state_q == RUN)
            frozen_d = ~frozen_q;
        else if (btn_lap && state_q == PAUSE)
            frozen_d = 1'b0;
    end

    // While unfrozen the display tracks the count, so holding it on the press edge keeps the pre-edge snapshot.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frozen_q <= 1'b0;
            disp_q   <= '0;
        end else begin
            frozen_q <= frozen_d;
            disp_q   <= frozen_d ? disp_q : cnt_d;
        end
    end

    assign {min_1, min_0, sec_1, sec_0} = disp_q;
`else
    logic unused_lap;
    assign unused_lap = btn_lap;

    assign {min_1, min_0, sec_1, sec_0} = cnt_q;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl (DIV=4): directed scenarios with literal expectations,
// then randomized buttons, all compared every cycle against a seconds/cycle-count model.
module tb_stopwatch_ctrl;

    localparam int DIV  = 4;
    localparam int HALF = DIV / 2;
    localparam int P_START = 0;
    localparam int P_CLEAR = 1;
    localparam int P_INC   = 2;
    localparam int P_LAP   = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       btn_start = 1'b0, btn_clear = 1'b0, btn_inc = 1'b0, btn_lap = 1'b0;
    logic       adj = 1'b0, sel = 1'b0;
    logic [3:0] min_1, min_0, sec_1, sec_0, blank;
    logic       running, tick;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    stopwatch_ctrl #(.DIV(DIV)) dut (
        .clock    (clock),
        .reset    (reset),
        .btn_start(btn_start),
        .btn_clear(btn_clear),
        .btn_inc  (btn_inc),
        .btn_lap  (btn_lap),
        .adj      (adj),
        .sel      (sel),
        .min_1    (min_1),
        .min_0    (min_0),
        .sec_1    (sec_1),
        .sec_0    (sec_0),
        .running  (running),
        .blank    (blank),
        .tick     (tick)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: time kept as plain minutes/seconds, second boundaries from cycles spent running.
    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_ADJ} mode_t;
    typedef struct {
        mode_t mode;
        int    mins;
        int    secs;
        int    run_cyc;
        int    adj_cyc;
        bit    frozen;
        int    snap_m;
        int    snap_s;
        bit    tick;
        bit    sel_s;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.mode = M_IDLE; r.mins = 0; r.secs = 0; r.run_cyc = 0; r.adj_cyc = 0;
        r.frozen = 1'b0; r.snap_m = 0; r.snap_s = 0; r.tick = 1'b0; r.sel_s = 1'b0;
        return r;
    endfunction

    function automatic model_t model_step(input model_t c, input bit st, input bit cl,
                                          input bit inc, input bit lap, input bit a, input bit s);
        model_t n = c;
        bit     second;
        int     total;
        n.tick  = 1'b0;
        n.sel_s = s;
        case (c.mode)
            M_IDLE: begin
                if (cl) begin n.mins = 0; n.secs = 0; end
                else if (st) begin n.mode = M_RUN; n.run_cyc = 0; end
                else if (a) begin n.mode = M_ADJ; n.adj_cyc = 0; end
            end
            M_RUN: begin
                n.run_cyc = c.run_cyc + 1;
                second    = (n.run_cyc % DIV) == 0;
                if (second && cl) begin
                    n.mins = 0; n.secs = 0; n.frozen = 1'b0;
                end else begin
`ifdef STOPWATCH_LAP_EN
                    if (lap) begin
                        n.frozen = !c.frozen;
                        n.snap_m = c.mins;
                        n.snap_s = c.secs;
                    end
`endif
                    if (second) begin
                        total  = (c.mins * 60 + c.secs + 1) % 3600;
                        n.mins = total / 60;
                        n.secs = total % 60;
                        n.tick = 1'b1;
                    end
                    if (st) n.mode = M_PAUSE;
                end
            end
            M_PAUSE: begin
                if (cl) begin
                    n.mode = M_IDLE; n.mins = 0; n.secs = 0; n.frozen = 1'b0;
                end else begin
                    if (lap) n.frozen = 1'b0;
                    if (st) begin n.mode = M_RUN; n.run_cyc = 0; end
                    else if (a) begin n.mode = M_ADJ; n.adj_cyc = 0; n.frozen = 1'b0; end
                end
            end
            M_ADJ: begin
                if (cl) begin
                    n.mins = 0; n.secs = 0; n.adj_cyc = c.adj_cyc + 1;
                end else if (!a) begin
                    n.mode = (c.mins == 0 && c.secs == 0) ? M_IDLE : M_PAUSE;
                end else if (inc) begin
                    if (s) n.secs = (c.secs + 1) % 60;
                    else   n.mins = (c.mins + 1) % 60;
                    n.adj_cyc = 0;
                end else begin
                    n.adj_cyc = c.adj_cyc + 1;
                end
            end
            default: n.mode = M_IDLE;
        endcase
        return n;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) m <= model_reset();
        else        m <= model_step(m, btn_start, btn_clear, btn_inc, btn_lap, adj, sel);
    end

    always @(negedge clock) begin
        int         sm, ss;
        logic [3:0] eb;
        if (cmp_en) begin
            sm = m.frozen ? m.snap_m : m.mins;
            ss = m.frozen ? m.snap_s : m.secs;
            eb = 4'b0000;
            if (m.mode == M_ADJ && ((m.adj_cyc / HALF) % 2) == 1)
                eb = m.sel_s ? 4'b0011 : 4'b1100;
            check("model_digits", {min_1, min_0, sec_1, sec_0},
                  {4'(sm / 10), 4'(sm % 10), 4'(ss / 10), 4'(ss % 10)});
            check("model_running", 16'(running), 16'(m.mode == M_RUN));
            check("model_tick", 16'(tick), 16'(m.tick));
            check("model_blank", 16'(blank), 16'(eb));
        end
    end

    task automatic pulse(input int which);
        case (which)
            P_START: btn_start = 1'b1;
            P_CLEAR: btn_clear = 1'b1;
            P_INC:   btn_inc   = 1'b1;
            default: btn_lap   = 1'b1;
        endcase
        @(negedge clock);
        btn_start = 1'b0; btn_clear = 1'b0; btn_inc = 1'b0; btn_lap = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ticks;

        repeat (3) @(negedge clock);
        check("reset_digits", {min_1, min_0, sec_1, sec_0}, 16'h0000);
        check("reset_flags", 16'({running, tick, blank}), 16'h0000);
        reset  = 1'b1;
        cmp_en = 1'b1;
        @(negedge clock);

        // First second lands exactly DIV cycles after start; 60 seconds rolls into 01:00.
        pulse(P_START);
        check("start_running", 16'(running), 16'h0001);
        repeat (DIV - 1) @(negedge clock);
        check("pre_first_tick", 16'({tick, sec_0}), 16'h0000);
        @(negedge clock);
        check("first_tick", 16'({tick, sec_0}), 16'h0011);
        repeat (59 * DIV) @(negedge clock);
        check("one_minute", {min_1, min_0, sec_1, sec_0}, 16'h0100);

        // Preload 59:59 through adjust, then run through the wrap.
        pulse(P_START);
        pulse(P_CLEAR);
        check("clear_from_pause", {min_1, min_0, sec_1, sec_0}, 16'h0000);
        adj = 1'b1;
        @(negedge clock);
        sel = 1'b0;
        repeat (59) pulse(P_INC);
        sel = 1'b1;
        repeat (59) pulse(P_INC);
        check("preload", {min_1, min_0, sec_1, sec_0}, 16'h5959);
        adj = 1'b0;
        @(negedge clock);
        pulse(P_START);
        repeat (DIV) @(negedge clock);
        check("wrap_digits", {min_1, min_0, sec_1, sec_0}, 16'h0000);
        check("wrap_run_tick", 16'({running, tick}), 16'h0003);

        // Pause at 00:07, clear to idle, then a clear while running off the wrap edge is ignored.
        repeat (7 * DIV) @(negedge clock);
        pulse(P_START);
        check("pause_digits", {min_1, min_0, sec_1, sec_0}, 16'h0007);
        check("pause_running", 16'(running), 16'h0000);
        pulse(P_CLEAR);
        check("idle_clear", {min_1, min_0, sec_1, sec_0}, 16'h0000);
        pulse(P_START);
        repeat (3 * DIV) @(negedge clock);
        pulse(P_CLEAR);
        check("run_clear_ignored", {min_1, min_0, sec_1, sec_0}, 16'h0003);
        check("run_clear_running", 16'(running), 16'h0001);

        // Clear on the wrap edge wins over the increment.
        repeat (DIV - 2) @(negedge clock);
        pulse(P_CLEAR);
        check("clear_at_wrap", {min_1, min_0, sec_1, sec_0}, 16'h0000);
        check("clear_at_wrap_tick", 16'(tick), 16'h0000);

        // Asynchronous reset mid-second.
        @(negedge clock);
        #2 reset = 1'b0;
        #1 check("async_reset", 16'({running, tick, blank, min_1, min_0, sec_1, sec_0} != 0), 16'h0000);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Adjust seconds 61 times: mod 60 with no carry, then watch the blink phase.
        sel = 1'b1;
        adj = 1'b1;
        @(negedge clock);
        repeat (61) pulse(P_INC);
        check("adj_no_carry", {min_1, min_0, sec_1, sec_0}, 16'h0001);
        check("blank_after_inc", 16'(blank), 16'h0000);
        @(negedge clock);
        check("blank_c1", 16'(blank), 16'h0000);
        @(negedge clock);
        check("blank_c2", 16'(blank), 16'h0003);
        repeat (2) @(negedge clock);
        check("blank_c4", 16'(blank), 16'h0000);
        sel = 1'b0;
        repeat (2) @(negedge clock);
        check("blank_minutes", 16'(blank), 16'h000C);
        adj = 1'b0;
        @(negedge clock);
        check("adj_exit", 16'({running, blank}), 16'h0000);

`ifdef STOPWATCH_LAP_EN
        // Lap freeze holds the display while the count and tick carry on.
        pulse(P_CLEAR);
        pulse(P_START);
        repeat (2 * DIV) @(negedge clock);
        pulse(P_LAP);
        ticks = 0;
        repeat (3 * DIV - 1) begin
            @(negedge clock);
            if (tick) ticks++;
        end
        check("lap_ticks", 16'(ticks), 16'h0003);
        check("lap_hold", {min_1, min_0, sec_1, sec_0}, 16'h0002);
        pulse(P_START);
        check("lap_hold_pause", {min_1, min_0, sec_1, sec_0}, 16'h0002);
        pulse(P_LAP);
        check("lap_release", {min_1, min_0, sec_1, sec_0}, 16'h0005);
`else
        ticks = 0;
`endif

        // Randomized buttons and levels, checked every cycle by the model.
        for (int i = 0; i < 4000; i++) begin
            btn_start = ($urandom_range(15) == 0);
            btn_clear = ($urandom_range(11) == 0);
            btn_inc   = ($urandom_range(3) == 0);
            btn_lap   = ($urandom_range(7) == 0);
            if ($urandom_range(40) == 0) adj = ~adj;
            if ($urandom_range(7) == 0)  sel = ~sel;
            @(negedge clock);
        end
        btn_start = 1'b0; btn_clear = 1'b0; btn_inc = 1'b0; btn_lap = 1'b0;
        @(negedge clock);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
